// File: rtl/bumpy_pkg.sv
// bumpy_pkg: game-flow states, tile-type codes shared with the movement FSM, and a width helper
package bumpy_pkg;
  typedef enum logic [3:0] {
    S_TITLE, S_LOAD, S_READY, S_PLAY, S_DYING, S_LEVEL_DONE, S_GAME_OVER, S_WIN
  } game_state_t;
  localparam logic [2:0] FREE = 3'd0, REGU = 3'd1, GATE = 3'd2, DEATH = 3'd3, WALL = 3'd4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/bumpy_frame_timer.sv
// bumpy_frame_timer: counts frame ticks since the last clear; done when the count equals len
module bumpy_frame_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic         hold,
  input  logic [W-1:0] len,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : (tick && !hold && !done) ? cnt + 1'b1 : cnt;
  assign done = cnt == len;
endmodule

// File: rtl/bumpy_game_ctrl.sv
// bumpy_game_ctrl: game-flow sequencer (title/load/ready/play/dying/level-done/game-over/win); BUMPY_PAUSE_EN adds pause
module bumpy_game_ctrl
  import bumpy_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_W      = 2,
  parameter int START_LIVES  = 3,
  parameter int LIVES_W      = 3,
  parameter int READY_FRAMES = 30,
  parameter int DEATH_FRAMES = 60,
  parameter int DONE_FRAMES  = 45
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               any_key,
  input  logic               pause_key,
  input  logic               die,
  input  logic               gate_reached,
  input  logic               load_done,
  output logic [3:0]         game_state,
  output logic               bumpy_resetN,
  output logic               level_load,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               freeze,
  output logic               game_over,
  output logic               win
);
  localparam int TW = $clog2(max3(READY_FRAMES, DEATH_FRAMES, DONE_FRAMES) + 1);
  game_state_t state, state_n;
  logic any_key_d, key_rise, tdone, paused, paused_n, last_level;
  logic bumpy_resetN_n, level_load_n, freeze_n, game_over_n, win_n;
  logic [TW-1:0] len;
  logic [LEVEL_W-1:0] level_n;
  logic [LIVES_W-1:0] lives_n;
  assign key_rise = any_key && !any_key_d;
  assign last_level = level == LEVEL_W'(NUM_LEVELS - 1);
  assign game_state = state;
  assign len = (state == S_READY) ? TW'(READY_FRAMES) :
               (state == S_DYING) ? TW'(DEATH_FRAMES) : TW'(DONE_FRAMES);
`ifdef BUMPY_PAUSE_EN
  logic pause_d;
  assign paused_n = (state_n != S_PLAY) ? 1'b0 :
                    paused ^ (state == S_PLAY && pause_key && !pause_d);
  always_ff @(posedge clk) begin
    pause_d <= reset ? 1'b0 : pause_key;
    paused  <= reset ? 1'b0 : paused_n;
  end
`else
  logic unused_pause;
  assign unused_pause = pause_key;
  assign paused = 1'b0;
  assign paused_n = 1'b0;
`endif
  bumpy_frame_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (state_n != state),
    .tick (startOfFrame),
    .hold (paused),
    .len  (len),
    .done (tdone)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_TITLE;
      any_key_d    <= 1'b0;
      level        <= '0;
      lives        <= LIVES_W'(START_LIVES);
      bumpy_resetN <= 1'b0;
      level_load   <= 1'b0;
      freeze       <= 1'b1;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      state        <= state_n;
      any_key_d    <= any_key;
      level        <= level_n;
      lives        <= lives_n;
      bumpy_resetN <= bumpy_resetN_n;
      level_load   <= level_load_n;
      freeze       <= freeze_n;
      game_over    <= game_over_n;
      win          <= win_n;
    end
  end
  // level_load is high exactly in the first S_LOAD cycle, so it also masks an early load_done
  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    case (state)
      S_TITLE:      state_n = key_rise ? S_LOAD : S_TITLE;
      S_LOAD:       state_n = (!level_load && load_done) ? S_READY : S_LOAD;
      S_READY:      state_n = tdone ? S_PLAY : S_READY;
      S_PLAY:       state_n = paused ? S_PLAY : die ? S_DYING : gate_reached ? S_LEVEL_DONE : S_PLAY;
      S_DYING: if (tdone) begin
        state_n = (lives <= LIVES_W'(1)) ? S_GAME_OVER : S_READY;
        lives_n = (lives == '0) ? '0 : lives - 1'b1;
      end
      S_LEVEL_DONE: if (tdone) begin
        state_n = last_level ? S_WIN : S_LOAD;
        level_n = last_level ? level : level + 1'b1;
      end
      S_GAME_OVER, S_WIN: if (key_rise) begin
        state_n = S_TITLE;
        level_n = '0;
        lives_n = LIVES_W'(START_LIVES);
      end
      default: state_n = S_TITLE;
    endcase
  end
  always_comb begin
    bumpy_resetN_n = state_n == S_PLAY || state_n == S_DYING;
    level_load_n   = state_n == S_LOAD && state != S_LOAD;
    freeze_n       = !(state_n == S_PLAY && !paused_n);
    game_over_n    = state_n == S_GAME_OVER;
    win_n          = state_n == S_WIN;
  end
endmodule

// File: tb/tb_bumpy_game_ctrl.sv
// tb_bumpy_game_ctrl: directed game-flow scenarios with hand-computed expectations; pause scenario under BUMPY_PAUSE_EN
module tb_bumpy_game_ctrl;
  localparam int ST_TITLE = 0, ST_LOAD = 1, ST_READY = 2, ST_PLAY = 3, ST_DYING = 4,
                 ST_LEVEL_DONE = 5, ST_GAME_OVER = 6, ST_WIN = 7;
  logic clk = 1'b0;
  logic reset, startOfFrame, any_key, pause_key, die, gate_reached, load_done;
  logic [3:0] game_state;
  logic bumpy_resetN, level_load, freeze, game_over, win;
  logic [1:0] level;
  logic [2:0] lives;
  int n_cmp = 0;
  int n_bad = 0;
  bumpy_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .any_key     (any_key),
    .pause_key   (pause_key),
    .die         (die),
    .gate_reached(gate_reached),
    .load_done   (load_done),
    .game_state  (game_state),
    .bumpy_resetN(bumpy_resetN),
    .level_load  (level_load),
    .level       (level),
    .lives       (lives),
    .freeze      (freeze),
    .game_over   (game_over),
    .win         (win)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      step(1);
      startOfFrame = 1'b0;
      step(1);
    end
  endtask
  task automatic press();
    any_key = 1'b1;
    step(1);
    any_key = 1'b0;
  endtask
  task automatic load();
    load_done = 1'b1;
    step(2);
    load_done = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    {startOfFrame, any_key, pause_key, die, gate_reached, load_done} = '0;
    step(2);
    chk("rst_state", int'(game_state), ST_TITLE);
    chk("rst_level", int'(level), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_resetN", int'(bumpy_resetN), 0);
    chk("rst_load", int'(level_load), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_over_win", int'({game_over, win}), 0);
    reset = 1'b0;
    step(1);
    press();
    chk("t1_load_state", int'(game_state), ST_LOAD);
    chk("t1_load_pulse", int'(level_load), 1);
    chk("t1_load_level", int'(level), 0);
    load_done = 1'b1;
    step(1);
    chk("t1_first_ignored", int'(game_state), ST_LOAD);
    chk("t1_load_one_cycle", int'(level_load), 0);
    step(1);
    load_done = 1'b0;
    chk("t1_ready", int'(game_state), ST_READY);
    chk("t1_ready_resetN", int'(bumpy_resetN), 0);
    frames(29);
    chk("t2_ready_29", int'(game_state), ST_READY);
    chk("t2_resetN_29", int'(bumpy_resetN), 0);
    frames(1);
    chk("t2_play", int'(game_state), ST_PLAY);
    chk("t2_play_resetN", int'(bumpy_resetN), 1);
    chk("t2_play_freeze", int'(freeze), 0);
    die = 1'b1;
    step(1);
    chk("t3_dying", int'(game_state), ST_DYING);
    chk("t3_dying_freeze", int'(freeze), 1);
    chk("t3_dying_resetN", int'(bumpy_resetN), 1);
    frames(59);
    chk("t3_dying_59", int'(game_state), ST_DYING);
    frames(1);
    die = 1'b0;
    chk("t3_ready", int'(game_state), ST_READY);
    chk("t3_lives", int'(lives), 2);
    chk("t3_resetN", int'(bumpy_resetN), 0);
    frames(30);
    die = 1'b1;
    step(1);
    frames(60);
    die = 1'b0;
    chk("t4_lives1", int'(lives), 1);
    frames(30);
    die = 1'b1;
    step(1);
    any_key = 1'b1;
    frames(60);
    die = 1'b0;
    chk("t4_over_state", int'(game_state), ST_GAME_OVER);
    chk("t4_over_lives", int'(lives), 0);
    chk("t4_over_flag", int'(game_over), 1);
    chk("t4_over_freeze", int'(freeze), 1);
    step(5);
    chk("t4_held_no_restart", int'(game_state), ST_GAME_OVER);
    any_key = 1'b0;
    step(1);
    press();
    chk("t4_title", int'(game_state), ST_TITLE);
    chk("t4_title_lives", int'(lives), 3);
    chk("t4_title_over", int'(game_over), 0);
    step(1);
    press();
    load();
    frames(30);
    die = 1'b1;
    gate_reached = 1'b1;
    step(1);
    die = 1'b0;
    gate_reached = 1'b0;
    chk("t5_die_wins", int'(game_state), ST_DYING);
    frames(60);
    frames(30);
    chk("t5_play_lives2", int'(lives), 2);
    for (int lv = 0; lv < 3; lv++) begin
      gate_reached = 1'b1;
      step(1);
      gate_reached = 1'b0;
      chk("t5_level_done", int'(game_state), ST_LEVEL_DONE);
      frames(45);
      chk("t5_next_load", int'(game_state), ST_LOAD);
      chk("t5_next_level", int'(level), lv + 1);
      chk("t5_next_pulse", int'(level_load), 1);
      load();
      frames(30);
    end
    gate_reached = 1'b1;
    step(1);
    gate_reached = 1'b0;
    frames(44);
    chk("t5_done_44", int'(game_state), ST_LEVEL_DONE);
    frames(1);
    chk("t5_win_state", int'(game_state), ST_WIN);
    chk("t5_win_flag", int'(win), 1);
    chk("t5_win_level", int'(level), 3);
    chk("t5_win_resetN", int'(bumpy_resetN), 0);
    press();
    chk("t5_title", int'(game_state), ST_TITLE);
    chk("t5_title_level", int'(level), 0);
    chk("t5_title_win", int'(win), 0);
    step(1);
    press();
    load();
    frames(30);
`ifdef BUMPY_PAUSE_EN
    pause_key = 1'b1;
    step(1);
    pause_key = 1'b0;
    chk("t6_paused_freeze", int'(freeze), 1);
    die = 1'b1;
    step(3);
    chk("t6_die_ignored", int'(game_state), ST_PLAY);
    die = 1'b0;
    pause_key = 1'b1;
    step(1);
    pause_key = 1'b0;
    chk("t6_resume_freeze", int'(freeze), 0);
    chk("t6_resume_state", int'(game_state), ST_PLAY);
`endif
    die = 1'b1;
    step(1);
    die = 1'b0;
    frames(60);
    frames(30);
    die = 1'b1;
    step(1);
    die = 1'b0;
    chk("t6_pre_reset_dying", int'(game_state), ST_DYING);
    chk("t6_pre_reset_lives", int'(lives), 2);
    frames(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t6_rst_state", int'(game_state), ST_TITLE);
    chk("t6_rst_lives", int'(lives), 3);
    chk("t6_rst_freeze", int'(freeze), 1);
    chk("t6_rst_resetN", int'(bumpy_resetN), 0);
    step(1);
    press();
    chk("t7_load_pulse", int'(level_load), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t7_rst_load_state", int'(game_state), ST_TITLE);
    chk("t7_rst_load_pulse", int'(level_load), 0);
    load();
    chk("t7_load_abandoned", int'(game_state), ST_TITLE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
